// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: "main" drives data_o, "skid" catches the payload accepted while downstream stalls.
// Optional performance counters are compiled in when PIPE_SKID_PERF_EN is defined.
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i
`ifdef PIPE_SKID_PERF_EN
    ,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  xfer_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              valid_r;
    logic              ready_r;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] skid_r;

    logic              in_s;
    logic              out_s;
    logic              load_main_s;
    logic              main_from_skid_s;
    logic              load_skid_s;

    // Handshakes use only registered flags, so ready_o/valid_o never depend on ready_i/valid_i.
    always_comb begin
        in_s  = valid_i & ready_r;
        out_s = valid_r & ready_i;
    end

    // Next-state and datapath-enable decode; flush overrides every transition and suppresses loads.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush_i) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_s) begin
                        load_main_s = 1'b1;
                        state_nxt_s = BUSY;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (in_s && out_s) begin
                        load_main_s = 1'b1;
                        state_nxt_s = BUSY;
                    end else if (in_s) begin
                        load_skid_s = 1'b1;
                        state_nxt_s = FULL;
                    end else if (out_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                FULL: begin
                    if (out_s) begin
                        main_from_skid_s = 1'b1;
                        state_nxt_s      = BUSY;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s != EMPTY);
            ready_r <= (state_nxt_s != FULL);
        end
    end

    // Payload storage; flush leaves contents untouched because no load is decoded.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            main_r <= {DATA_W{1'b0}};
            skid_r <= {DATA_W{1'b0}};
        end else begin
            if (load_main_s) begin
                main_r <= data_i;
            end else if (main_from_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= data_i;
            end
        end
    end

    assign valid_o = valid_r;
    assign ready_o = ready_r;
    assign data_o  = main_r;

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] xfer_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Saturating event counters; clear wins over any increment in the same cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            xfer_cnt_r   <= {CNT_W{1'b0}};
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_i) begin
            xfer_cnt_r   <= {CNT_W{1'b0}};
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_s) begin
                xfer_cnt_r <= sat_inc(xfer_cnt_r);
            end
            if (valid_r && !ready_i) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (!valid_r) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end
        end
    end

    assign xfer_cnt_o   = xfer_cnt_r;
    assign stall_cnt_o  = stall_cnt_r;
    assign bubble_cnt_o = bubble_cnt_r;
`else
    logic [CNT_W-1:0] unused_cnt_w_s;
    assign unused_cnt_w_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, reset/flush corner sequences,
// and a randomized run against a two-entry FIFO reference model.
module tb_pipe_skid_stage;

    logic        clk_i;
    logic        reset_i;
    logic        flush_i;
    logic        valid_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic        ready_i;
`ifdef PIPE_SKID_PERF_EN
    logic        cnt_clr_i;
    logic [3:0]  xfer_cnt_o;
    logic [3:0]  stall_cnt_o;
    logic [3:0]  bubble_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

`ifdef PIPE_SKID_PERF_EN
    pipe_skid_stage #(.DATA_W(64), .CNT_W(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
        .cnt_clr_i(cnt_clr_i), .xfer_cnt_o(xfer_cnt_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );
`else
    pipe_skid_stage #(.DATA_W(64)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i)
    );
`endif

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush;
        logic        valid;
        logic [63:0] data;
        logic        ready;
        logic        exp_valid;
        logic        exp_ready;
        logic        chk_data;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic v, input logic [63:0] d, input logic r,
                       input logic ev, input logic er, input logic cd, input logic [63:0] ed);
        vec_t t;
        t.flush = f; t.valid = v; t.data = d; t.ready = r;
        t.exp_valid = ev; t.exp_ready = er; t.chk_data = cd; t.exp_data = ed;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic f, input logic v, input logic [63:0] d, input logic r);
        flush_i = f; valid_i = v; data_i = d; ready_i = r;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
`ifdef PIPE_SKID_PERF_EN
        cnt_clr_i = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", {63'h0, valid_o}, 64'h0);
        check("rst_ready", {63'h0, ready_o}, 64'h1);
        check("rst_data", data_o, 64'h0);
        reset_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [63:0] q[$];
        logic        in_t;
        logic        out_t;
        int          delivered;

        reset_i = 1'b0;
        do_reset();

`ifdef PIPE_SKID_PERF_EN
        // Counter saturation, stall counting and clear priority with a 4-bit counter.
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        check("perf_clr0_xfer", {60'h0, xfer_cnt_o}, 64'h0);
        check("perf_clr0_bubble", {60'h0, bubble_cnt_o}, 64'h0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 64'(i + 100), 1'b1);
            step();
        end
        check("perf_xfer_sat", {60'h0, xfer_cnt_o}, 64'd15);
        check("perf_bubble", {60'h0, bubble_cnt_o}, 64'd1);
        check("perf_stall0", {60'h0, stall_cnt_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 64'(i + 200), 1'b0);
            step();
        end
        check("perf_stall3", {60'h0, stall_cnt_o}, 64'd3);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        check("perf_clr_xfer", {60'h0, xfer_cnt_o}, 64'd0);
        check("perf_clr_stall", {60'h0, stall_cnt_o}, 64'd0);
        check("perf_clr_bubble", {60'h0, bubble_cnt_o}, 64'd0);
        do_reset();
`endif

        // Directed vectors; expectations are the outputs after the edge that consumes the inputs.
        add(1'b0, 1'b1, 64'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 64'hA5);
        for (int k = 1; k <= 8; k++) add(1'b0, 1'b1, 64'(k), 1'b1, 1'b1, 1'b1, 1'b1, 64'(k));
        add(1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b0, 1'b1, 64'h11, 1'b0, 1'b1, 1'b1, 1'b1, 64'h11);
        add(1'b0, 1'b1, 64'h22, 1'b0, 1'b1, 1'b0, 1'b1, 64'h11);
        add(1'b0, 1'b1, 64'h99, 1'b0, 1'b1, 1'b0, 1'b1, 64'h11);
        add(1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 1'b1, 64'h22);
        add(1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b0, 1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 1'b1, 64'h33);
        add(1'b0, 1'b1, 64'h44, 1'b0, 1'b1, 1'b0, 1'b1, 64'h33);
        add(1'b1, 1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b1, 1'b1, 64'h77, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].valid, vecs[i].data, vecs[i].ready);
            step();
            check($sformatf("vec%0d_valid", i), {63'h0, valid_o}, {63'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d_ready", i), {63'h0, ready_o}, {63'h0, vecs[i].exp_ready});
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
        end

        // Asynchronous reset between edges while FULL, then 1-cycle latency after release.
        drive(1'b0, 1'b1, 64'h33, 1'b0);
        step();
        drive(1'b0, 1'b1, 64'h44, 1'b0);
        step();
        check("arst_pre_full", {63'h0, ready_o}, 64'h0);
        #2;
        reset_i = 1'b0;
        #1;
        check("arst_valid_now", {63'h0, valid_o}, 64'h0);
        check("arst_ready_now", {63'h0, ready_o}, 64'h1);
        drive(1'b0, 1'b1, 64'hEE, 1'b1);
        step();
        step();
        check("arst_ignore_in", {63'h0, valid_o}, 64'h0);
        reset_i = 1'b1;
        drive(1'b0, 1'b1, 64'h66, 1'b1);
        step();
        check("arst_post_valid", {63'h0, valid_o}, 64'h1);
        check("arst_post_data", data_o, 64'h66);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        step();
        check("arst_drain", {63'h0, valid_o}, 64'h0);

        // Randomized traffic against a two-deep FIFO model.
        do_reset();
        delivered = 0;
        for (int c = 0; c < 10000; c++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
                  {$urandom, $urandom}, $urandom_range(0, 2) != 0);
            check("rnd_valid", {63'h0, valid_o}, {63'h0, q.size() != 0});
            check("rnd_ready", {63'h0, ready_o}, {63'h0, q.size() < 2});
            if (q.size() != 0) check("rnd_data", data_o, q[0]);
            in_t  = valid_i && (q.size() < 2);
            out_t = (q.size() != 0) && ready_i;
            step();
            if (out_t) begin
                void'(q.pop_front());
                delivered++;
            end
            if (flush_i) q.delete();
            else if (in_t) q.push_back(data_i);
        end
        check("rnd_progress", {63'h0, delivered > 1000}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
